// File: rtl/sysmem_bus_ctrl.sv
// PicoRV32 native-bus bridge to four byte-lane system-memory BRAMs, with a
// byte-stream loader port that fills the same lanes with a program image.
module sysmem_bus_ctrl #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic                  ld_ovf,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [3:0]            bram_ce,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_di,
  input  logic [31:0]           bram_do
);

  localparam int PW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] PTR_ONE = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          mem_ready_q, mem_ready_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ld_ovf_q, ld_ovf_d;

  logic          in_range;
  logic [3:0]    lane_sel;
  logic          unused_addr_bits;

  assign in_range         = (mem_addr[31:PW] == ADDR_BASE[31:PW]);
  assign lane_sel         = 4'b0001 << ptr_q[1:0];
  assign unused_addr_bits = ^mem_addr[1:0];

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ld_ovf    = ld_ovf_q;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case leaves a signal unassigned (no latches).
    state_d     = state_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ptr_d       = ptr_q;
    ld_ovf_d    = ld_ovf_q;
    ld_ready    = 1'b0;
    bram_addr   = mem_addr[PW-1:2];
    bram_ce     = 4'h0;
    bram_we     = 4'h0;
    bram_di     = mem_wdata;

    if (ld_start) begin
      ptr_d    = '0;
      ld_ovf_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!ld_start) begin
          if (ld_valid) begin
            // Loader bytes always win over the CPU; after a wrap they are
            // still acknowledged but no longer reach the BRAM.
            ld_ready  = 1'b1;
            bram_addr = ptr_q[PW-1:2];
            bram_di   = {4{ld_data}};
            if (!ld_ovf_q) begin
              bram_ce = lane_sel;
              bram_we = lane_sel;
            end
            ptr_d = ptr_q + PTR_ONE;
            if (&ptr_q) ld_ovf_d = 1'b1;
          end else if (mem_valid && in_range) begin
            bram_ce = 4'hF;
            bram_we = mem_wstrb;
            if (|mem_wstrb) begin
              state_d     = S_ACK;
              mem_ready_d = 1'b1;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        mem_rdata_d = bram_do;
        mem_ready_d = 1'b1;
        state_d     = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Keep the BRAMs and the loader handshake quiet while reset is held.
    if (rsta) begin
      ld_ready = 1'b0;
      bram_ce  = 4'h0;
      bram_we  = 4'h0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, regardless of block order.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q     <= S_IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      ptr_q       <= '0;
      ld_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      ptr_q       <= ptr_d;
      ld_ovf_q    <= ld_ovf_d;
    end
  end

endmodule
